// File: rtl/rocc_pkg.sv
// rtl/rocc_pkg.sv - shared types and constants for the RoCC command issuer
//   rocc_inst_t   : RoCC instruction word fields carried with each command
//   ROCC_XLEN     : default operand/result width
//   CUSTOM0..3    : custom-instruction major opcodes
//   fence_state_e : fence drain FSM states
package rocc_pkg;

  localparam int ROCC_XLEN = 64;

  localparam logic [6:0] CUSTOM0 = 7'h0B;
  localparam logic [6:0] CUSTOM1 = 7'h2B;
  localparam logic [6:0] CUSTOM2 = 7'h5B;
  localparam logic [6:0] CUSTOM3 = 7'h7B;

  typedef struct packed {
    logic [6:0] funct;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic       xd;
    logic       xs1;
    logic       xs2;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rocc_inst_t;

  typedef enum logic [1:0] {
    FSM_RUN   = 2'd0,
    FSM_DRAIN = 2'd1,
    FSM_ACK   = 2'd2
  } fence_state_e;

endpackage

// File: rtl/rocc_scoreboard.sv
// rtl/rocc_scoreboard.sv - destination-register scoreboard for in-flight xd commands
//   clk, rst_n            : clock, asynchronous active-low reset
//   set_i / set_rd_i      : mark rd pending (rd 0 ignored)
//   clr_i / clr_rd_i      : response arriving for rd; clears only if pending
//   query_rd_i, hazard_o  : pending lookup for the requesting rd
//   full_o, empty_o       : outstanding count at limit / zero
//   clr_hit_o             : response rd is nonzero and currently pending
module rocc_scoreboard #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_i,
  input  logic [4:0] set_rd_i,
  input  logic       clr_i,
  input  logic [4:0] clr_rd_i,
  input  logic [4:0] query_rd_i,
  output logic       hazard_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       clr_hit_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_set, do_clr;

  assign clr_hit_o = (clr_rd_i != 5'd0) && pend_q[clr_rd_i];
  assign hazard_o  = pend_q[query_rd_i];
  assign full_o    = (cnt_q == CW'(MAX_OUTSTANDING));
  assign empty_o   = (cnt_q == '0);

  // Set and clear never target the same rd (the issuer stalls on hazards),
  // so a simultaneous set/clear leaves the count unchanged.
  always_comb begin
    do_set = set_i && (set_rd_i != 5'd0);
    do_clr = clr_i && clr_hit_o;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (do_clr) pend_d[clr_rd_i] = 1'b0;
    if (do_set) pend_d[set_rd_i] = 1'b1;
    if (do_set && !do_clr)      cnt_d = cnt_q + CW'(1);
    else if (!do_set && do_clr) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/rocc_cmd_issuer.sv
// rtl/rocc_cmd_issuer.sv - core-side RoCC command issuer with scoreboard, writeback and fence
//   clk, reset                : clock, asynchronous active-low reset
//   req_*                     : pipeline issue handshake and decoded instruction/operands
//   io_cmd_*                  : registered command toward the accelerator
//   io_resp_*                 : accelerator responses (always accepted)
//   wb_valid/wb_rd/wb_data    : register-file writeback, one cycle after a response
//   fence_req / fence_ack     : drain request / one-cycle completion pulse
//   busy, err_unexpected      : activity indication, sticky stray-response flag
//   err_timeout               : sticky watchdog flag (ROCC_ISSUER_TIMEOUT_EN)
module rocc_cmd_issuer
  import rocc_pkg::*;
#(
  parameter int XLEN            = ROCC_XLEN,
  parameter int MAX_OUTSTANDING = 4
`ifdef ROCC_ISSUER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [6:0]      req_funct,
  input  logic [6:0]      req_opcode,
  input  logic [4:0]      req_rs1_idx,
  input  logic [4:0]      req_rs2_idx,
  input  logic [4:0]      req_rd,
  input  logic            req_xd,
  input  logic            req_xs1,
  input  logic            req_xs2,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  output logic            io_cmd_valid,
  input  logic            io_cmd_ready,
  output logic [6:0]      io_cmd_bits_inst_funct,
  output logic [4:0]      io_cmd_bits_inst_rs2,
  output logic [4:0]      io_cmd_bits_inst_rs1,
  output logic            io_cmd_bits_inst_xd,
  output logic            io_cmd_bits_inst_xs1,
  output logic            io_cmd_bits_inst_xs2,
  output logic [4:0]      io_cmd_bits_inst_rd,
  output logic [6:0]      io_cmd_bits_inst_opcode,
  output logic [XLEN-1:0] io_cmd_bits_rs1,
  output logic [XLEN-1:0] io_cmd_bits_rs2,
  input  logic            io_resp_valid,
  output logic            io_resp_ready,
  input  logic [4:0]      io_resp_bits_rd,
  input  logic [XLEN-1:0] io_resp_bits_data,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic            fence_req,
  output logic            fence_ack,
  output logic            busy,
  output logic            err_unexpected,
  output logic            err_timeout
);

  fence_state_e    state_q;
  logic            fence_ack_q;
  logic            slot_q;
  rocc_inst_t      inst_q;
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic            wb_valid_q;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q;
  logic            err_unexp_q;

  logic sb_hazard, sb_full, sb_empty, sb_hit;
  logic req_fire, cmd_fire, req_tracked;

  assign req_tracked = req_xd && (req_rd != 5'd0);
  // Gated by reset so the pipeline never sees ready while the block is held.
  assign req_ready = reset && (!slot_q || io_cmd_ready) && (state_q == FSM_RUN) &&
                     !(req_tracked && (sb_hazard || sb_full));
  assign req_fire  = req_valid && req_ready;
  assign cmd_fire  = slot_q && io_cmd_ready;

  rocc_scoreboard #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_sb (
    .clk        (clk),
    .rst_n      (reset),
    .set_i      (req_fire && req_xd),
    .set_rd_i   (req_rd),
    .clr_i      (io_resp_valid),
    .clr_rd_i   (io_resp_bits_rd),
    .query_rd_i (req_rd),
    .hazard_o   (sb_hazard),
    .full_o     (sb_full),
    .empty_o    (sb_empty),
    .clr_hit_o  (sb_hit)
  );

  // Command slot: a new load wins over the drain when both happen together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q <= 1'b0;
      inst_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
    end else if (req_fire) begin
      slot_q <= 1'b1;
      inst_q <= '{funct: req_funct, rs2: req_rs2_idx, rs1: req_rs1_idx, xd: req_xd,
                  xs1: req_xs1, xs2: req_xs2, rd: req_rd, opcode: req_opcode};
      rs1_q  <= req_rs1;
      rs2_q  <= req_rs2;
    end else if (cmd_fire) begin
      slot_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FSM_RUN;
      fence_ack_q <= 1'b0;
    end else begin
      fence_ack_q <= 1'b0;
      unique case (state_q)
        FSM_RUN:   if (fence_req) state_q <= FSM_DRAIN;
        FSM_DRAIN: if (!slot_q && sb_empty) begin
          state_q     <= FSM_ACK;
          fence_ack_q <= 1'b1;
        end
        FSM_ACK:   state_q <= FSM_RUN;
        default:   state_q <= FSM_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      err_unexp_q <= 1'b0;
    end else begin
      wb_valid_q <= io_resp_valid && sb_hit;
      if (io_resp_valid && sb_hit) begin
        wb_rd_q   <= io_resp_bits_rd;
        wb_data_q <= io_resp_bits_data;
      end
      if (io_resp_valid && (io_resp_bits_rd != 5'd0) && !sb_hit) err_unexp_q <= 1'b1;
    end
  end

`ifdef ROCC_ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;
  logic          err_to_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
      err_to_q <= 1'b0;
    end else begin
      if (io_resp_valid || sb_empty)              to_cnt_q <= '0;
      else if (to_cnt_q != TW'(TIMEOUT_CYCLES))   to_cnt_q <= to_cnt_q + TW'(1);
      if (to_cnt_q == TW'(TIMEOUT_CYCLES))        err_to_q <= 1'b1;
    end
  end
  assign err_timeout = err_to_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign io_cmd_valid            = slot_q;
  assign io_cmd_bits_inst_funct  = inst_q.funct;
  assign io_cmd_bits_inst_rs2    = inst_q.rs2;
  assign io_cmd_bits_inst_rs1    = inst_q.rs1;
  assign io_cmd_bits_inst_xd     = inst_q.xd;
  assign io_cmd_bits_inst_xs1    = inst_q.xs1;
  assign io_cmd_bits_inst_xs2    = inst_q.xs2;
  assign io_cmd_bits_inst_rd     = inst_q.rd;
  assign io_cmd_bits_inst_opcode = inst_q.opcode;
  assign io_cmd_bits_rs1         = rs1_q;
  assign io_cmd_bits_rs2         = rs2_q;
  assign io_resp_ready           = 1'b1;
  assign wb_valid                = wb_valid_q;
  assign wb_rd                   = wb_rd_q;
  assign wb_data                 = wb_data_q;
  assign fence_ack               = fence_ack_q;
  assign busy                    = slot_q || !sb_empty;
  assign err_unexpected          = err_unexp_q;

endmodule

// File: tb/tb_rocc_cmd_issuer.sv
// tb/tb_rocc_cmd_issuer.sv - directed self-checking bench for rocc_cmd_issuer
module tb_rocc_cmd_issuer;
  import rocc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [6:0]  req_funct = '0, req_opcode = '0;
  logic [4:0]  req_rs1_idx = '0, req_rs2_idx = '0, req_rd = '0;
  logic        req_xd = 1'b0, req_xs1 = 1'b0, req_xs2 = 1'b0;
  logic [63:0] req_rs1 = '0, req_rs2 = '0;
  logic        io_cmd_valid, io_cmd_ready = 1'b1;
  logic [6:0]  c_funct, c_opcode;
  logic [4:0]  c_rs2, c_rs1, c_rd;
  logic        c_xd, c_xs1, c_xs2;
  logic [63:0] c_rs1v, c_rs2v;
  logic        io_resp_valid = 1'b0, io_resp_ready;
  logic [4:0]  io_resp_bits_rd = '0;
  logic [63:0] io_resp_bits_data = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        fence_req = 1'b0, fence_ack, busy, err_unexpected, err_timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rocc_cmd_issuer #(
    .XLEN(64), .MAX_OUTSTANDING(4)
`ifdef ROCC_ISSUER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct(req_funct), .req_opcode(req_opcode),
    .req_rs1_idx(req_rs1_idx), .req_rs2_idx(req_rs2_idx), .req_rd(req_rd),
    .req_xd(req_xd), .req_xs1(req_xs1), .req_xs2(req_xs2),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready),
    .io_cmd_bits_inst_funct(c_funct), .io_cmd_bits_inst_rs2(c_rs2),
    .io_cmd_bits_inst_rs1(c_rs1), .io_cmd_bits_inst_xd(c_xd),
    .io_cmd_bits_inst_xs1(c_xs1), .io_cmd_bits_inst_xs2(c_xs2),
    .io_cmd_bits_inst_rd(c_rd), .io_cmd_bits_inst_opcode(c_opcode),
    .io_cmd_bits_rs1(c_rs1v), .io_cmd_bits_rs2(c_rs2v),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_bits_rd(io_resp_bits_rd), .io_resp_bits_data(io_resp_bits_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .fence_req(fence_req), .fence_ack(fence_ack), .busy(busy),
    .err_unexpected(err_unexpected), .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input logic [4:0] rd, input logic xd, input logic [63:0] a, input logic [63:0] b);
    req_valid = 1'b1; req_rd = rd; req_xd = xd; req_xs1 = 1'b1; req_xs2 = 1'b1;
    req_funct = 7'd0; req_opcode = CUSTOM0; req_rs1_idx = 5'd1; req_rs2_idx = 5'd2;
    req_rs1 = a; req_rs2 = b;
  endtask

  task automatic resp(input logic [4:0] rd, input logic [63:0] d);
    io_resp_valid = 1'b1; io_resp_bits_rd = rd; io_resp_bits_data = d;
  endtask

  initial begin
    // Reset values
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_cmd_valid", io_cmd_valid, 0);
    chk("rst_payload", c_rs1v, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_fence_ack", fence_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_unexp", err_unexpected, 0);
    chk("rst_err_to", err_timeout, 0);
    chk("resp_ready", io_resp_ready, 1);
    reset = 1'b1;
    tick();

    // Single xd command rd=5, 3+4 -> response 7
    set_req(5'd5, 1'b1, 64'd3, 64'd4);
    #1 chk("t1_ready", req_ready, 1);
    tick(); req_valid = 1'b0;
    #1 chk("t1_cmd_valid", io_cmd_valid, 1);
    chk("t1_rs1", c_rs1v, 3);
    chk("t1_rs2", c_rs2v, 4);
    chk("t1_rd", c_rd, 5);
    chk("t1_opcode", c_opcode, 7'h0B);
    chk("t1_busy_slot", busy, 1);
    tick();
    #1 chk("t1_cmd_empty", io_cmd_valid, 0);
    chk("t1_busy_pend", busy, 1);
    tick(); resp(5'd5, 64'd7);
    #1 chk("t1_no_wb_yet", wb_valid, 0);
    tick(); io_resp_valid = 1'b0;
    #1 chk("t1_wb_valid", wb_valid, 1);
    chk("t1_wb_rd", wb_rd, 5);
    chk("t1_wb_data", wb_data, 7);
    chk("t1_busy_done", busy, 0);
    tick();
    #1 chk("t1_wb_pulse", wb_valid, 0);

    // Back-to-back rd=5: second stalls until cycle after the response
    set_req(5'd5, 1'b1, 64'h11, 64'h0);
    #1 chk("t2_first_ready", req_ready, 1);
    tick(); set_req(5'd5, 1'b1, 64'h10, 64'h0);
    #1 chk("t2_hazard_a", req_ready, 0);
    tick(); resp(5'd5, 64'h55);
    #1 chk("t2_hazard_b", req_ready, 0);
    tick(); io_resp_valid = 1'b0;
    #1 chk("t2_ready_after", req_ready, 1);
    chk("t2_wb_data", wb_data, 64'h55);
    tick(); req_valid = 1'b0;
    #1 chk("t2_cmd_valid", io_cmd_valid, 1);
    chk("t2_cmd_rs1", c_rs1v, 64'h10);
    tick(); resp(5'd5, 64'h1);
    tick(); io_resp_valid = 1'b0;
    #1 chk("t2_wb2", wb_valid, 1);
    chk("t2_idle", busy, 0);

    // Four outstanding, rd=6 stalls on full, count stays at the limit
    set_req(5'd1, 1'b1, 64'd0, 64'd0); tick();
    set_req(5'd2, 1'b1, 64'd0, 64'd0); tick();
    set_req(5'd3, 1'b1, 64'd0, 64'd0); tick();
    set_req(5'd4, 1'b1, 64'd0, 64'd0); tick();
    set_req(5'd6, 1'b1, 64'd0, 64'd0);
    #1 chk("t3_full_stall", req_ready, 0);
    resp(5'd3, 64'h33);
    #1 chk("t3_full_stall_resp", req_ready, 0);
    tick(); io_resp_valid = 1'b0;
    #1 chk("t3_rd6_ready", req_ready, 1);
    chk("t3_wb_rd3", wb_rd, 3);
    tick(); set_req(5'd7, 1'b1, 64'd0, 64'd0);
    #1 chk("t3_full_again", req_ready, 0);
    req_valid = 1'b0;
    resp(5'd1, 64'h0); tick();
    resp(5'd2, 64'h0); tick();
    resp(5'd4, 64'h0); tick();
    resp(5'd6, 64'h66); tick();
    io_resp_valid = 1'b0;
    #1 chk("t3_wb_rd6", wb_rd, 6);
    chk("t3_wb_data6", wb_data, 64'h66);
    chk("t3_idle", busy, 0);

    // io_cmd_ready low for 3 cycles: payload stable, handshake on 4th
    io_cmd_ready = 1'b0;
    set_req(5'd8, 1'b0, 64'hAAAA, 64'h0);
    #1 chk("t4_accept_empty", req_ready, 1);
    tick(); set_req(5'd9, 1'b0, 64'hBBBB, 64'h0);
    #1 chk("t4_blocked", req_ready, 0);
    chk("t4_stable1", c_rs1v, 64'hAAAA);
    tick();
    #1 chk("t4_stable2", c_rs1v, 64'hAAAA);
    tick();
    #1 chk("t4_stable3", c_rs1v, 64'hAAAA);
    chk("t4_valid_held", io_cmd_valid, 1);
    tick(); io_cmd_ready = 1'b1;
    #1 chk("t4_ready_full", req_ready, 1);
    chk("t4_stable4", c_rs1v, 64'hAAAA);
    tick(); req_valid = 1'b0;
    #1 chk("t4_next_valid", io_cmd_valid, 1);
    chk("t4_next_rs1", c_rs1v, 64'hBBBB);
    chk("t4_next_rd", c_rd, 9);
    tick();
    #1 chk("t4_drained", io_cmd_valid, 0);

    // Fence with rd=2 outstanding
    set_req(5'd2, 1'b1, 64'd0, 64'd0);
    tick(); req_valid = 1'b0;
    tick(); fence_req = 1'b1;
    tick(); fence_req = 1'b0; set_req(5'd10, 1'b0, 64'hC, 64'h0);
    #1 chk("t5_drain_block", req_ready, 0);
    tick(); resp(5'd2, 64'h22);
    #1 chk("t5_drain_block2", req_ready, 0);
    chk("t5_no_ack", fence_ack, 0);
    tick(); io_resp_valid = 1'b0;
    #1 chk("t5_no_ack_yet", fence_ack, 0);
    tick();
    #1 chk("t5_ack", fence_ack, 1);
    chk("t5_ack_block", req_ready, 0);
    tick();
    #1 chk("t5_ack_pulse", fence_ack, 0);
    chk("t5_run_ready", req_ready, 1);
    tick(); req_valid = 1'b0;
    #1 chk("t5_issued", c_rs1v, 64'hC);
    tick();

    // rd=0 response is silently dropped; rd=9 is unexpected
    resp(5'd0, 64'h1);
    tick(); resp(5'd9, 64'h9);
    #1 chk("t6_rd0_no_wb", wb_valid, 0);
    chk("t6_rd0_no_err", err_unexpected, 0);
    tick(); io_resp_valid = 1'b0;
    #1 chk("t6_rd9_no_wb", wb_valid, 0);
    chk("t6_rd9_err", err_unexpected, 1);

    // Never-answered rd=1
    set_req(5'd1, 1'b1, 64'd0, 64'd0);
    tick(); req_valid = 1'b0;
`ifdef ROCC_ISSUER_TIMEOUT_EN
    for (int i = 0; i < 9; i++) tick();
    #1 chk("t7_to_early", err_timeout, 0);
    for (int i = 0; i < 30 && !err_timeout; i++) tick();
    #1 chk("t7_to_set", err_timeout, 1);
`else
    for (int i = 0; i < 20; i++) tick();
    #1 chk("t7_to_tied", err_timeout, 0);
`endif
    chk("t8_busy_pre", busy, 1);

    // Reset mid-operation discards the scoreboard
    reset = 1'b0;
    #1 chk("t8_rst_busy", busy, 0);
    chk("t8_rst_err", err_unexpected, 0);
    chk("t8_rst_to", err_timeout, 0);
    chk("t8_rst_ready", req_ready, 0);
    tick(); reset = 1'b1;
    tick(); resp(5'd1, 64'h5);
    tick(); io_resp_valid = 1'b0;
    #1 chk("t8_stale_no_wb", wb_valid, 0);
    chk("t8_stale_err", err_unexpected, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
